core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Multi-cycle control FSM for the ucrv32 core. Sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU and register file.
- Owns the PC and the instruction register. Drives the instruction and data memory handshakes.
- Turns decoder class flags and exception flags into register-file write enables, PC updates and traps.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded when a trap is taken.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- imem_req_o  out  1  instruction fetch request.
- imem_addr_o  out  32  fetch address, equal to pc_o.
- imem_ack_i  in  1  fetch done; imem_rdata_i valid.
- imem_rdata_i  in  32  fetched word.
- instruction_o  out  32  instruction register, fed to the decoder.
- dec_opcode_i  in  7  decoded opcode.
- dec_rd_i  in  5  destination register.
- dec_immediate_i  in  32  decoded immediate.
- dec_exception_i  in  1  illegal instruction flag.
- dec_jal_i, dec_branch_i, dec_reg2mem_i, dec_mem2reg_i, dec_alu_writeback_i, dec_syscall_i  in  1 each  decoder class flags.
- branch_taken_i  in  1  ALU compare result.
- alu_result_i  in  32  ALU output.
- dmem_req_o  out  1  data access request.
- dmem_we_o  out  1  1 = store, 0 = load.
- dmem_ack_i  in  1  data access done.
- rf_we_o  out  1  register-file write enable, 1-cycle pulse.
- rf_wsel_o  out  2  write-data select: 0 = ALU, 1 = memory, 2 = pc+4.
- pc_o  out  32  current PC.
- retire_o  out  1  1-cycle pulse per completed instruction.
- trap_o  out  1  1-cycle pulse when a trap is taken.
- trap_cause_o  out  2  0 = illegal, 1 = ecall, 2 = misaligned target; held until the next trap.

Behaviour:
- Reset, synchronous on rst_i, also mid-operation:
  - state IDLE, pc_o = RESET_PC, instruction_o = 0, trap_cause_o = 0.
  - All strobes/requests 0: imem_req_o, dmem_req_o, rf_we_o, retire_o, trap_o.
  - Outstanding memory requests are abandoned.
- IDLE: one cycle, no requests, acks ignored; -> FETCH.
- FETCH:
  - imem_req_o = 1; imem_addr_o = pc_o.
  - Ack is sampled every cycle req is high, including the first.
  - On ack: instruction_o <= imem_rdata_i; -> DECODE. Otherwise stay, req held high.
- DECODE (1 cycle):
  - dec_exception_i -> TRAP, cause 0.
  - dec_syscall_i -> TRAP, cause 1.
  - else -> EXECUTE.
- EXECUTE (1 cycle):
  - Computes next_pc:
    - JAL: pc + imm.
    - JALR (opcode 7'b1100111): alu_result_i & ~32'h1.
    - Branch with branch_taken_i: pc + imm.
    - Otherwise: pc + 4.
  - All additions wrap modulo 2^32.
  - next_pc[1:0] != 0 -> TRAP, cause 2; pc unchanged; no register write.
  - dec_reg2mem_i or dec_mem2reg_i -> MEM. Otherwise -> WB.
- MEM:
  - dmem_req_o = 1; dmem_we_o = dec_reg2mem_i.
  - Held until dmem_ack_i; on ack -> WB.
- WB (1 cycle):
  - pc <= next_pc; retire_o = 1.
  - rf_we_o = 1 when (dec_alu_writeback_i or dec_mem2reg_i) and dec_rd_i != 0.
  - rf_wsel_o: 2 for JAL/JALR, 1 for load, 0 otherwise.
  - -> FETCH.
- TRAP (1 cycle):
  - trap_o = 1; trap_cause_o latched; pc <= TRAP_PC; no retire.
  - -> FETCH.
- Latency with same-cycle acks:
  - ALU/branch/jump instructions: 4 cycles, fetch to retire.
  - Load/store: 5 cycles.
  - Each wait cycle on an ack adds 1.
- Acks arriving while the matching req is low are ignored.
- The ack and rst_i in the same cycle: reset wins.
- rf_wsel_o is 0 whenever rf_we_o = 0.

Test Plan:
- Reset, then ADDI x1,x0,5 with imem ack on the first cycle, ALU result 5 -> retire_o at cycle 4 after IDLE; rf_we_o = 1, rf_wsel_o = 0; pc_o becomes 0x4.
- LW x2 with imem and dmem acks delayed 2 cycles each -> dmem_req_o held 3 cycles with dmem_we_o = 0; rf_wsel_o = 1; retire at cycle 9; ADDI to x0 -> rf_we_o stays 0.
- JAL with imm 0x10 at pc 0x8 -> pc_o = 0x18, rf_wsel_o = 2. BEQ with imm -8 at pc 0x0, taken -> pc_o = 0xFFFF_FFF8 (wrap). JALR with ALU result 0x21 -> pc_o = 0x20.
- dec_exception_i at DECODE -> trap_o pulse, trap_cause_o = 0, pc_o = 0x100, no retire. ECALL -> cause 1. JAL with imm 0x2 -> cause 2, no rf_we_o.
- rst_i asserted during a MEM wait -> next cycle IDLE, pc_o = 0, dmem_req_o = 0. A dmem_ack_i pulse in the IDLE cycle is ignored; fetch restarts from 0x0.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer - multi-cycle control FSM of the ucrv32 core.
//
// Walks every instruction through FETCH, DECODE, EXECUTE, optional MEM and WB,
// with a TRAP detour for illegal instructions, ecalls and misaligned targets.
// Owns the PC and the instruction register.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   imem_req_o/addr_o       instruction fetch request, address (= pc_o)
//   imem_ack_i/rdata_i      fetch completion and fetched word
//   instruction_o           instruction register, feeds the decoder
//   dec_*_i                 decoder results for instruction_o
//   branch_taken_i          ALU compare result
//   alu_result_i            ALU output (JALR target source)
//   dmem_req_o/we_o/ack_i   data memory handshake (we: 1 = store)
//   rf_we_o, rf_wsel_o      register-file write strobe and data select
//                           (0 = ALU, 1 = memory, 2 = pc+4)
//   pc_o                    current PC
//   retire_o                one-cycle pulse per completed instruction
//   trap_o, trap_cause_o    trap pulse; cause (0 illegal, 1 ecall,
//                           2 misaligned) held until the next trap
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instruction_o,
  input  logic [6:0]  dec_opcode_i,
  input  logic [4:0]  dec_rd_i,
  input  logic [31:0] dec_immediate_i,
  input  logic        dec_exception_i,
  input  logic        dec_jal_i,
  input  logic        dec_branch_i,
  input  logic        dec_reg2mem_i,
  input  logic        dec_mem2reg_i,
  input  logic        dec_alu_writeback_i,
  input  logic        dec_syscall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] alu_result_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ack_i,
  output logic        rf_we_o,
  output logic [1:0]  rf_wsel_o,
  output logic [31:0] pc_o,
  output logic        retire_o,
  output logic        trap_o,
  output logic [1:0]  trap_cause_o
);

  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [1:0] CAUSE_ILLEGAL    = 2'd0;
  localparam logic [1:0] CAUSE_ECALL      = 2'd1;
  localparam logic [1:0] CAUSE_MISALIGNED = 2'd2;

  localparam logic [1:0] WSEL_ALU = 2'd0;
  localparam logic [1:0] WSEL_MEM = 2'd1;
  localparam logic [1:0] WSEL_PC4 = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] next_pc_q;
  logic [1:0]  cause_q, cause_d;

  logic [31:0] next_pc_calc;
  logic        is_jalr;
  logic        misaligned;
  logic        mem_op;
  logic        rf_write;

  // Target selection. JALR takes priority so a decoder that also raises
  // dec_jal_i for JALR still gets the register-relative target.
  always_comb begin
    is_jalr      = (dec_opcode_i == OPC_JALR);
    next_pc_calc = pc_q + 32'd4;
    if (is_jalr) begin
      next_pc_calc = alu_result_i & ~32'h1;
    end else if (dec_jal_i) begin
      next_pc_calc = pc_q + dec_immediate_i;
    end else if (dec_branch_i && branch_taken_i) begin
      next_pc_calc = pc_q + dec_immediate_i;
    end
    misaligned = |next_pc_calc[1:0];
    mem_op     = dec_reg2mem_i | dec_mem2reg_i;
    rf_write   = (dec_alu_writeback_i | dec_mem2reg_i) && (dec_rd_i != 5'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cause_q <= CAUSE_ILLEGAL;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // The trap cause is captured on the transition into TRAP so it is already
  // valid while trap_o pulses.
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    imem_req_o   = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    rf_we_o      = 1'b0;
    rf_wsel_o    = WSEL_ALU;
    retire_o     = 1'b0;
    trap_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_exception_i) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (dec_syscall_i) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ECALL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        if (misaligned) begin
          state_d = S_TRAP;
          cause_d = CAUSE_MISALIGNED;
        end else if (mem_op) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = dec_reg2mem_i;
        if (dmem_ack_i) state_d = S_WB;
      end
      S_WB: begin
        retire_o = 1'b1;
        rf_we_o  = rf_write;
        if (rf_write) begin
          if (is_jalr || dec_jal_i) begin
            rf_wsel_o = WSEL_PC4;
          end else if (dec_mem2reg_i) begin
            rf_wsel_o = WSEL_MEM;
          end else begin
            rf_wsel_o = WSEL_ALU;
          end
        end
        state_d = S_FETCH;
      end
      S_TRAP: begin
        trap_o  = 1'b1;
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // PC, instruction register and the target computed in EXECUTE. The PC only
  // moves in WB or TRAP, so a misaligned target never reaches pc_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q      <= RESET_PC;
      instr_q   <= 32'd0;
      next_pc_q <= RESET_PC;
    end else begin
      if (state_q == S_FETCH && imem_ack_i) instr_q <= imem_rdata_i;
      if (state_q == S_EXECUTE) next_pc_q <= next_pc_calc;
      if (state_q == S_WB) pc_q <= next_pc_q;
      if (state_q == S_TRAP) pc_q <= TRAP_PC;
    end
  end

  assign pc_o          = pc_q;
  assign imem_addr_o   = pc_q;
  assign instruction_o = instr_q;
  assign trap_cause_o  = cause_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer - directed self-checking bench for core_sequencer.
// Each instruction's expected outcome is derived from a reference model and
// queued when the instruction is driven; it is popped and compared when the
// sequencer retires or traps.
module tb_core_sequencer;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] TRAP_PC   = 32'h0000_0100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instruction_o;
  logic [6:0]  dec_opcode_i;
  logic [4:0]  dec_rd_i;
  logic [31:0] dec_immediate_i;
  logic        dec_exception_i;
  logic        dec_jal_i;
  logic        dec_branch_i;
  logic        dec_reg2mem_i;
  logic        dec_mem2reg_i;
  logic        dec_alu_writeback_i;
  logic        dec_syscall_i;
  logic        branch_taken_i;
  logic [31:0] alu_result_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ack_i;
  logic        rf_we_o;
  logic [1:0]  rf_wsel_o;
  logic [31:0] pc_o;
  logic        retire_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;

  core_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .instruction_o(instruction_o),
    .dec_opcode_i(dec_opcode_i), .dec_rd_i(dec_rd_i),
    .dec_immediate_i(dec_immediate_i), .dec_exception_i(dec_exception_i),
    .dec_jal_i(dec_jal_i), .dec_branch_i(dec_branch_i),
    .dec_reg2mem_i(dec_reg2mem_i), .dec_mem2reg_i(dec_mem2reg_i),
    .dec_alu_writeback_i(dec_alu_writeback_i), .dec_syscall_i(dec_syscall_i),
    .branch_taken_i(branch_taken_i), .alu_result_i(alu_result_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
    .rf_we_o(rf_we_o), .rf_wsel_o(rf_wsel_o), .pc_o(pc_o),
    .retire_o(retire_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        exc, sys, jal, br, taken, st, ld, aluwb;
    logic [31:0] alu;
    logic [31:0] word;
    int          imem_delay;
    int          dmem_delay;
  } instr_t;

  typedef struct {
    int          latency;
    logic        trap;
    logic [1:0]  cause;
    logic        we;
    logic [1:0]  wsel;
    logic [31:0] pc;
    int          dmem_cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] pc_model;
  instr_t      cur;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: observed simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic instr_t blank_instr();
    instr_t t;
    t.opcode = OPC_OPIMM; t.rd = 5'd0; t.imm = 32'd0;
    t.exc = 0; t.sys = 0; t.jal = 0; t.br = 0; t.taken = 0;
    t.st = 0; t.ld = 0; t.aluwb = 0; t.alu = 32'd0; t.word = 32'h0000_0013;
    t.imem_delay = 0; t.dmem_delay = 0;
    return t;
  endfunction

  // Reference model of the architectural outcome of one instruction.
  function automatic exp_t model(input instr_t t, input logic [31:0] pc);
    exp_t e;
    logic [31:0] npc;
    int fetch_cycles;
    fetch_cycles  = t.imem_delay + 1;
    e.trap        = 0;
    e.cause       = 2'd0;
    e.we          = 0;
    e.wsel        = 2'd0;
    e.dmem_cycles = 0;
    if (t.opcode == OPC_JALR)   npc = {t.alu[31:1], 1'b0};
    else if (t.jal)             npc = pc + t.imm;
    else if (t.br && t.taken)   npc = pc + t.imm;
    else                        npc = pc + 32'd4;
    if (t.exc || t.sys) begin
      e.trap = 1; e.cause = t.exc ? 2'd0 : 2'd1;
      e.pc = TRAP_PC; e.latency = fetch_cycles + 2;
    end else if (npc[1:0] != 2'b00) begin
      e.trap = 1; e.cause = 2'd2;
      e.pc = TRAP_PC; e.latency = fetch_cycles + 3;
    end else begin
      e.pc = npc;
      e.latency = fetch_cycles + 3;
      if (t.st || t.ld) begin
        e.dmem_cycles = t.dmem_delay + 1;
        e.latency     = e.latency + e.dmem_cycles;
      end
      e.we = (t.aluwb || t.ld) && (t.rd != 5'd0);
      if (e.we) e.wsel = (t.jal || t.opcode == OPC_JALR) ? 2'd2 : (t.ld ? 2'd1 : 2'd0);
    end
    return e;
  endfunction

  task automatic drive_decoder(input instr_t t);
    dec_opcode_i        = t.opcode;
    dec_rd_i            = t.rd;
    dec_immediate_i     = t.imm;
    dec_exception_i     = t.exc;
    dec_syscall_i       = t.sys;
    dec_jal_i           = t.jal;
    dec_branch_i        = t.br;
    branch_taken_i      = t.taken;
    dec_reg2mem_i       = t.st;
    dec_mem2reg_i       = t.ld;
    dec_alu_writeback_i = t.aluwb;
    alu_result_i        = t.alu;
    imem_rdata_i        = t.word;
  endtask

  // Runs one instruction from its first fetch cycle to retire/trap.
  task automatic apply_stimulus(input string name, input instr_t t);
    exp_t e, got;
    int   w, cyc, fcnt, mcnt, we_cnt;
    bit   done, we_bad;
    logic obs_we, obs_trap, obs_ret;
    logic [1:0] obs_wsel;
    drive_decoder(t);
    sb.push_back(model(t, pc_model));
    w = 0;
    while (!imem_req_o && w < 10) begin step(); w++; end
    check_output({name, ".fetch_req"}, 32'(imem_req_o), 32'd1);
    check_output({name, ".imem_addr"}, imem_addr_o, pc_model);
    cyc = 0; fcnt = 0; mcnt = 0; we_cnt = 0; done = 0; we_bad = 0;
    obs_we = 0; obs_trap = 0; obs_ret = 0; obs_wsel = 2'd0;
    while (!done && cyc < 40) begin
      cyc++;
      imem_ack_i = imem_req_o && (fcnt == t.imem_delay);
      if (imem_req_o) fcnt++;
      dmem_ack_i = dmem_req_o && (mcnt == t.dmem_delay);
      if (dmem_req_o) begin
        mcnt++;
        if (dmem_we_o !== t.st) we_bad = 1;
      end
      #1;
      if (rf_we_o) we_cnt++;
      if (retire_o || trap_o) begin
        done = 1; obs_we = rf_we_o; obs_wsel = rf_wsel_o;
        obs_trap = trap_o; obs_ret = retire_o;
      end
      step();
    end
    imem_ack_i = 0;
    dmem_ack_i = 0;
    got = sb.pop_front();
    check_output({name, ".done"},     32'(done),     32'd1);
    check_output({name, ".latency"},  32'(cyc),      32'(got.latency));
    check_output({name, ".retire"},   32'(obs_ret),  32'(!got.trap));
    check_output({name, ".trap"},     32'(obs_trap), 32'(got.trap));
    check_output({name, ".rf_we"},    32'(obs_we),   32'(got.we));
    check_output({name, ".rf_wsel"},  32'(obs_wsel), 32'(got.wsel));
    check_output({name, ".we_count"}, 32'(we_cnt),   32'(got.we));
    check_output({name, ".dmem_cycles"}, 32'(mcnt),  32'(got.dmem_cycles));
    check_output({name, ".dmem_we"},  32'(we_bad),   32'd0);
    check_output({name, ".pc"},       pc_o,          got.pc);
    check_output({name, ".instr"},    instruction_o, t.word);
    if (got.trap) check_output({name, ".cause"}, 32'(trap_cause_o), 32'(got.cause));
    pc_model = got.pc;
  endtask

  initial begin
    int w;
    rst_i = 1; imem_ack_i = 0; dmem_ack_i = 0;
    drive_decoder(blank_instr());
    step(); step();

    check_output("rst.pc",        pc_o,                 32'h0);
    check_output("rst.instr",     instruction_o,        32'h0);
    check_output("rst.imem_req",  32'(imem_req_o),      32'd0);
    check_output("rst.dmem_req",  32'(dmem_req_o),      32'd0);
    check_output("rst.strobes",   32'({rf_we_o, retire_o, trap_o}), 32'd0);
    check_output("rst.cause",     32'(trap_cause_o),    32'd0);

    // IDLE cycle: acks must be ignored.
    rst_i = 0; imem_ack_i = 1; dmem_ack_i = 1; imem_rdata_i = 32'hDEAD_BEEF;
    step();
    imem_ack_i = 0; dmem_ack_i = 0;
    check_output("idle.instr",    instruction_o,        32'h0);
    check_output("idle.imem_req", 32'(imem_req_o),      32'd1);
    pc_model = 32'h0;

    cur = blank_instr(); cur.rd = 5'd1; cur.imm = 32'd5; cur.aluwb = 1;
    cur.alu = 32'd5; cur.word = 32'h0050_0093;
    apply_stimulus("addi_x1", cur);

    cur = blank_instr(); cur.opcode = OPC_LOAD; cur.rd = 5'd2; cur.ld = 1;
    cur.alu = 32'h40; cur.word = 32'h0400_2103; cur.imem_delay = 2; cur.dmem_delay = 2;
    apply_stimulus("lw_x2", cur);

    cur = blank_instr(); cur.opcode = OPC_JAL; cur.rd = 5'd1; cur.jal = 1;
    cur.aluwb = 1; cur.imm = 32'h10; cur.word = 32'h0100_00EF;
    apply_stimulus("jal", cur);

    cur = blank_instr(); cur.rd = 5'd0; cur.aluwb = 1; cur.imm = 32'd7;
    cur.alu = 32'd7; cur.word = 32'h0070_0013; cur.imem_delay = 1;
    apply_stimulus("addi_x0", cur);

    cur = blank_instr(); cur.opcode = OPC_STORE; cur.rd = 5'd5; cur.st = 1;
    cur.alu = 32'h80; cur.word = 32'h0820_2023; cur.dmem_delay = 1;
    apply_stimulus("sw", cur);

    cur = blank_instr(); cur.opcode = OPC_BRANCH; cur.br = 1; cur.taken = 0;
    cur.imm = 32'hFFFF_FFF8; cur.word = 32'hFE00_0CE3;
    apply_stimulus("beq_nt", cur);

    cur = blank_instr(); cur.opcode = OPC_JALR; cur.rd = 5'd0; cur.aluwb = 1;
    cur.alu = 32'h1; cur.word = 32'h0010_8067;
    apply_stimulus("jalr_x0", cur);

    cur = blank_instr(); cur.opcode = OPC_BRANCH; cur.br = 1; cur.taken = 1;
    cur.imm = 32'hFFFF_FFF8; cur.word = 32'hFE00_0CE3;
    apply_stimulus("beq_wrap", cur);

    cur = blank_instr(); cur.opcode = OPC_JALR; cur.rd = 5'd1; cur.aluwb = 1;
    cur.alu = 32'h21; cur.word = 32'h0210_80E7;
    apply_stimulus("jalr", cur);

    cur = blank_instr(); cur.exc = 1; cur.rd = 5'd3; cur.aluwb = 1;
    cur.word = 32'hFFFF_FFFF;
    apply_stimulus("illegal", cur);

    cur = blank_instr(); cur.opcode = OPC_SYSTEM; cur.sys = 1; cur.word = 32'h0000_0073;
    apply_stimulus("ecall", cur);

    cur = blank_instr(); cur.opcode = OPC_JAL; cur.rd = 5'd1; cur.jal = 1;
    cur.aluwb = 1; cur.imm = 32'h2; cur.word = 32'h0020_00EF;
    apply_stimulus("jal_misalign", cur);

    // Reset while a load waits in MEM.
    cur = blank_instr(); cur.opcode = OPC_LOAD; cur.rd = 5'd4; cur.ld = 1;
    cur.word = 32'h0000_2203;
    drive_decoder(cur);
    w = 0;
    while (!dmem_req_o && w < 20) begin
      imem_ack_i = imem_req_o;
      #1;
      step();
      w++;
    end
    imem_ack_i = 0;
    check_output("rstmem.dmem_req", 32'(dmem_req_o), 32'd1);
    step();
    check_output("rstmem.held", 32'(dmem_req_o), 32'd1);
    rst_i = 1;
    step();
    check_output("rstmem.pc",       pc_o,               32'h0);
    check_output("rstmem.dmem_req", 32'(dmem_req_o),    32'd0);
    check_output("rstmem.imem_req", 32'(imem_req_o),    32'd0);
    check_output("rstmem.cause",    32'(trap_cause_o),  32'd0);
    rst_i = 0; dmem_ack_i = 1; imem_ack_i = 1;
    step();
    dmem_ack_i = 0; imem_ack_i = 0;
    check_output("rstmem.instr",     instruction_o,     32'h0);
    check_output("rstmem.imem_addr", imem_addr_o,       32'h0);
    check_output("rstmem.refetch",   32'(imem_req_o),   32'd1);
    pc_model = 32'h0;

    cur = blank_instr(); cur.rd = 5'd6; cur.aluwb = 1; cur.alu = 32'd9;
    cur.word = 32'h0090_0313;
    apply_stimulus("addi_after_rst", cur);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
